slt_share_arbiter: RTL and testbench

Shares one combinational 64-bit signed less-than comparator between two requesters: port 0 (ALU SLT/SLTI/SLTU/SLTIU) and port 1 (branch unit BLT/BGE/BLTU/BGEU).
- Per-request arbitration, with branch priority and an ALU starvation guard, or plain round-robin.
- Unsigned and inverted-sense compares are mapped onto the signed comparator.
- Result is registered once and tagged with the requester ID; the output register supports backpressure.
- Sits beside the EX stage of the pipelined core.

---
 rtl/cmp_pkg.sv | 18 +
 rtl/signed_lt_comparator.sv | 12 +
 rtl/slt_share_arbiter.sv | 101 ++++++++++
 tb/tb_slt_share_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the compare datapath.
//   - op encodings for requester compare ops (bit0 = unsigned, bit1 = invert)
//   - requester port IDs
//   - default operand width
package cmp_pkg;
  localparam int XLEN_DEF = 64;

  localparam logic [1:0] CMP_LT  = 2'b00;  // SLT / BLT
  localparam logic [1:0] CMP_LTU = 2'b01;  // SLTU / BLTU
  localparam logic [1:0] CMP_GE  = 2'b10;  // BGE
  localparam logic [1:0] CMP_GEU = 2'b11;  // BGEU

  localparam int OP_UNS = 0;  // op bit: unsigned compare
  localparam int OP_INV = 1;  // op bit: invert sense (GE)

  localparam logic PORT_ALU = 1'b0;
  localparam logic PORT_BR  = 1'b1;
endpackage

// File: rtl/signed_lt_comparator.sv
// Combinational signed less-than comparator.
//   reg1, reg2 : operands (two's complement)
//   lt         : 1 when reg1 < reg2 (signed)
module signed_lt_comparator #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] reg1,
  input  logic [XLEN-1:0] reg2,
  output logic            lt
);
  assign lt = $signed(reg1) < $signed(reg2);
endmodule

// File: rtl/slt_share_arbiter.sv
// Shares one signed less-than comparator between the ALU (port 0) and the
// branch unit (port 1). One request is granted per cycle; the result is
// registered once, tagged with the requester ID, and held under backpressure.
//   clk, rst_n              : clock, async active-low reset
//   req_valid / req_ready   : per-port handshake (bit0 = ALU, bit1 = branch)
//   req{0,1}_a/_b/_op       : operands and op (bit0 unsigned, bit1 invert)
//   rsp_valid / rsp_ready   : result register handshake
//   rsp_id, rsp_result      : owning requester and compare outcome
module slt_share_arbiter
  import cmp_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter bit BRANCH_PRIO  = 1'b1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [1:0]      req0_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  input  logic [1:0]      req1_op,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic            rsp_result
);
  logic       adv;
  logic [1:0] gnt;
  logic       rr_last;
  logic [3:0] starve_cnt;
  logic       starved;

  assign adv     = !rsp_valid | rsp_ready;
  assign starved = (starve_cnt == 4'(STARVE_LIMIT));

  always_comb begin
    gnt = 2'b00;
    case (req_valid)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        if (BRANCH_PRIO) gnt = starved ? 2'b01 : 2'b10;
        else             gnt = rr_last ? 2'b01 : 2'b10;
      end
      default: gnt = 2'b00;
    endcase
  end

  assign req_ready = gnt & {2{adv}};

  logic fire;
  assign fire = |req_ready;

  // Operand mux ahead of the shared comparator; ungranted inputs never reach it.
  logic            sel;
  logic [XLEN-1:0] a, b, a_m, b_m;
  logic [1:0]      op;
  logic            lt, res;

  assign sel = gnt[PORT_BR];
  assign a   = sel ? req1_a  : req0_a;
  assign b   = sel ? req1_b  : req0_b;
  assign op  = sel ? req1_op : req0_op;

  // Flipping the MSB of both operands turns unsigned ordering into signed ordering.
  assign a_m = {a[XLEN-1] ^ op[OP_UNS], a[XLEN-2:0]};
  assign b_m = {b[XLEN-1] ^ op[OP_UNS], b[XLEN-2:0]};

  signed_lt_comparator #(.XLEN(XLEN)) u_cmp (
    .reg1 (a_m),
    .reg2 (b_m),
    .lt   (lt)
  );

  assign res = lt ^ op[OP_INV];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 1'b0;
      rr_last    <= 1'b1;
      starve_cnt <= 4'd0;
    end else if (adv) begin
      rsp_valid <= fire;
      if (fire) begin
        rsp_id     <= sel;
        rsp_result <= res;
        rr_last    <= sel;
        if (!sel)
          starve_cnt <= 4'd0;
        else if (req_valid[0] && !starved)
          starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_slt_share_arbiter.sv
// Directed bench: one priority-mode instance and one round-robin instance
// driven by the same requester inputs.
module tb_slt_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic        rsp_ready;

  logic [1:0]  rdy, rdy_rr;
  logic        rv, rid, rres, rv_rr, rid_rr, rres_rr;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  slt_share_arbiter #(.XLEN(64), .BRANCH_PRIO(1'b1), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rv), .rsp_ready(rsp_ready), .rsp_id(rid), .rsp_result(rres)
  );

  slt_share_arbiter #(.XLEN(64), .BRANCH_PRIO(1'b0), .STARVE_LIMIT(3)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_rr),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rv_rr), .rsp_ready(rsp_ready), .rsp_id(rid_rr), .rsp_result(rres_rr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] g_prio [8];
  logic       g_rr   [6];

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    req0_a = '0; req0_b = '0; req0_op = 2'b00;
    req1_a = '0; req1_b = '0; req1_op = 2'b00;
    #3;
    check("rst_rsp_valid",  rv,   1'b0);
    check("rst_rsp_id",     rid,  1'b0);
    check("rst_rsp_result", rres, 1'b0);
    check("rst_req_ready",  rdy,  2'b00);
    tick(); tick();
    rst_n = 1'b1;

    // single port 0 signed: -5 < 3
    req_valid = 2'b01; req0_a = -64'sd5; req0_b = 64'sd3; req0_op = 2'b00;
    #1 check("t1_ready", rdy, 2'b01);
    tick();
    check("t1_valid",  rv,   1'b1);
    check("t1_id",     rid,  1'b0);
    check("t1_result", rres, 1'b1);
    req_valid = 2'b00;
    tick();
    check("t1_drain", rv, 1'b0);

    // port 1 only: unsigned / signed / GE mapping, back-to-back
    req_valid = 2'b10; req1_a = 64'hFFFF_FFFF_FFFF_FFFF; req1_b = 64'd1; req1_op = 2'b01;
    #1 check("t2_ready", rdy, 2'b10);
    tick();
    check("t2_ltu_id",  rid,  1'b1);
    check("t2_ltu_res", rres, 1'b0);
    req1_op = 2'b00;
    tick();
    check("t2_lt_valid", rv,   1'b1);
    check("t2_lt_res",   rres, 1'b1);
    req1_a = 64'd7; req1_b = 64'd7; req1_op = 2'b10;
    tick();
    check("t2_ge_eq", rres, 1'b1);
    req1_a = 64'd1; req1_b = 64'hFFFF_FFFF_FFFF_FFFF; req1_op = 2'b11;
    tick();
    check("t2_geu_res", rres, 1'b0);
    req1_a = 64'd9; req1_b = 64'd9; req1_op = 2'b01;
    tick();
    check("t2_ltu_eq", rres, 1'b0);
    req_valid = 2'b00;
    tick();

    // contention with branch priority, starvation limit 3
    req0_a = 64'd1; req0_b = 64'd2; req0_op = 2'b00;  // -> 1
    req1_a = 64'd5; req1_b = 64'd2; req1_op = 2'b00;  // -> 0
    req_valid = 2'b11;
    g_prio = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 8; i++) begin
      #1 check($sformatf("t3_gnt%0d", i), rdy, g_prio[i]);
      tick();
      check($sformatf("t3_id%0d", i),  rid,  g_prio[i][1]);
      check($sformatf("t3_res%0d", i), rres, g_prio[i][0]);
    end

    // backpressure: port-0 result (id 0, result 1) is held
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("t5_ready%0d", i), rdy, 2'b00);
      tick();
      check($sformatf("t5_valid%0d", i), rv,   1'b1);
      check($sformatf("t5_id%0d", i),    rid,  1'b0);
      check($sformatf("t5_res%0d", i),   rres, 1'b1);
    end
    rsp_ready = 1'b1;
    #1 check("t5_release_ready", rdy, 2'b10);
    tick();
    check("t5_next_valid", rv,  1'b1);
    check("t5_next_id",    rid, 1'b1);
    tick();  // second port-1 win, starve count now 2

    // async reset mid-cycle while a result is held
    #3 rst_n = 1'b0;
    #1;
    check("t6_valid",    rv,    1'b0);
    check("t6_valid_rr", rv_rr, 1'b0);
    check("t6_id",       rid,   1'b0);
    tick();
    rst_n = 1'b1;
    #1 check("t6_no_rsp", rv, 1'b0);

    // out of reset: priority restarts from count 0, round-robin starts at port 0
    g_rr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t6_gnt%0d", i),    rdy,    g_prio[i]);
      check($sformatf("t4_rr_gnt%0d", i), rdy_rr, g_rr[i] ? 2'b10 : 2'b01);
      tick();
      check($sformatf("t4_rr_id%0d", i),  rid_rr, g_rr[i]);
      check($sformatf("t6_id%0d", i),     rid,    g_prio[i][1]);
      #1;
    end

    req_valid = 2'b00;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
